// File: rtl/gc_pkg.sv
// Shared definitions for the controller status-response receiver.
//   - bit-timing constants (PCLK cycles at 100 MHz, 4 us per bit)
//   - field bit offsets inside the 64-bit status word
//   - receiver state enumeration
package gc_pkg;

  localparam int BIT_CYCLES        = 400;             // one 4 us bit
  localparam int DEF_SAMPLE_DLY    = BIT_CYCLES / 2;  // bit midpoint after falling edge
  localparam int DEF_BIT_TIMEOUT   = 800;             // two bit times with no edge
  localparam int DEF_START_TIMEOUT = 50000;           // 500 us for the controller to answer
  localparam int DEF_NBITS         = 64;

  // Field LSB positions in the status word (bit 63 is received first).
  localparam int BUTTONS_LSB  = 48;
  localparam int JOY_X_LSB    = 40;
  localparam int JOY_Y_LSB    = 32;
  localparam int CSTICK_X_LSB = 24;
  localparam int CSTICK_Y_LSB = 16;
  localparam int TRIG_L_LSB   = 8;
  localparam int TRIG_R_LSB   = 0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    SAMPLE,
    WAIT_EDGE,
    HOLD
  } rx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gc_line_sync.sv
// Brings the asynchronous controller data line into the clk domain and
// detects its falling edges.
//   clk, rst_n : clock and asynchronous active-low reset
//   line_in    : raw data line (idles high through the external pull-up)
//   sync       : synchronized line level
//   fall       : one-cycle pulse on a synchronized high-to-low transition
// All flops reset to 1 so that releasing reset never fabricates an edge.
module gc_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic sync,
  output logic fall
);

  logic meta;
  logic prev;

  // NOTE: clocked state uses non-blocking assignments so the three flops
  // form a true shift chain regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall = prev & ~sync;

endmodule

// File: rtl/gc_response_rx.sv
// Receiver for the controller's 64-bit status response on the single-wire bus.
// Armed while `read` is high; each bit's low-pulse width is judged by sampling
// the line SAMPLE_DLY cycles after its falling edge (high = short pulse = 1).
//   PCLK, PRESETn      : clock and asynchronous active-low reset
//   read               : receive window from the poll transmitter
//   line_in            : raw controller data line
//   data_out           : last complete frame, bit 63 received first
//   buttons .. trig_r  : field slices of data_out
//   data_valid         : one-cycle pulse when data_out updates
//   timeout_err        : one-cycle pulse on start or inter-bit timeout
//   busy               : receiver is actively capturing a frame
module gc_response_rx
  import gc_pkg::*;
#(
  parameter int SAMPLE_DLY    = DEF_SAMPLE_DLY,
  parameter int BIT_TIMEOUT   = DEF_BIT_TIMEOUT,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int NBITS         = DEF_NBITS
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             read,
  input  logic             line_in,
  output logic [NBITS-1:0] data_out,
  output logic [15:0]      buttons,
  output logic [7:0]       joy_x,
  output logic [7:0]       joy_y,
  output logic [7:0]       cstick_x,
  output logic [7:0]       cstick_y,
  output logic [7:0]       trig_l,
  output logic [7:0]       trig_r,
  output logic             data_valid,
  output logic             timeout_err,
  output logic             busy
);

  localparam int TW = $clog2(max_int(START_TIMEOUT, BIT_TIMEOUT) + 1);
  localparam int CW = $clog2(NBITS + 1);

  localparam logic [TW-1:0] SAMPLE_LAST = TW'(SAMPLE_DLY - 1);
  localparam logic [TW-1:0] START_LAST  = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] EDGE_LAST   = TW'(BIT_TIMEOUT - 1);
  localparam logic [CW-1:0] LAST_BIT    = CW'(NBITS - 1);

  rx_state_t        state;
  rx_state_t        state_next;
  logic [TW-1:0]    timer;
  logic [CW-1:0]    bit_cnt;
  logic [NBITS-1:0] shreg;
  logic             capture_q;

  logic sync;
  logic fall;

  // Control strobes from the next-state logic.
  logic timer_clr;
  logic frame_clr;
  logic shift_en;
  logic frame_done;
  logic tmo;

  gc_line_sync u_sync (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .line_in (line_in),
    .sync    (sync),
    .fall    (fall)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    timer_clr  = 1'b0;
    frame_clr  = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    tmo        = 1'b0;

    if (!read) begin
      // Window closed: abandon whatever was in progress without any pulse.
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          frame_clr  = 1'b1;
          timer_clr  = 1'b1;
          state_next = WAIT_START;
        end
        WAIT_START: begin
          if (fall) begin
            timer_clr  = 1'b1;
            state_next = SAMPLE;
          end else if (timer == START_LAST) begin
            tmo        = 1'b1;
            state_next = HOLD;
          end
        end
        SAMPLE: begin
          // Falling edges here are glitches inside the bit and are ignored.
          if (timer == SAMPLE_LAST) begin
            shift_en = 1'b1;
            if (bit_cnt == LAST_BIT) begin
              frame_done = 1'b1;
              state_next = HOLD;
            end else begin
              timer_clr  = 1'b1;
              state_next = WAIT_EDGE;
            end
          end
        end
        WAIT_EDGE: begin
          if (fall) begin
            timer_clr  = 1'b1;
            state_next = SAMPLE;
          end else if (timer == EDGE_LAST) begin
            tmo        = 1'b1;
            state_next = HOLD;
          end
        end
        HOLD: begin
          // One capture attempt per window; the stop bit lands here.
          state_next = HOLD;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy = (state == WAIT_START) || (state == SAMPLE) || (state == WAIT_EDGE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      timer       <= '0;
      bit_cnt     <= '0;
      // NOTE: the shift register is a plain register bank, so it is reset
      // like any other state; it is also cleared at the start of every window.
      shreg       <= '0;
      capture_q   <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (timer_clr) begin
        timer <= '0;
      end else if (busy) begin
        timer <= timer + TW'(1);
      end

      if (frame_clr) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + CW'(1);
        shreg   <= {shreg[NBITS-2:0], sync};
      end

      // The last bit lands in shreg on the sample edge; publish one cycle
      // later unless the window closed in between.
      capture_q <= frame_done;
      if (capture_q && read) begin
        data_out <= shreg;
      end
      data_valid  <= capture_q & read;
      timeout_err <= tmo;
    end
  end

  assign buttons  = data_out[BUTTONS_LSB  +: 16];
  assign joy_x    = data_out[JOY_X_LSB    +: 8];
  assign joy_y    = data_out[JOY_Y_LSB    +: 8];
  assign cstick_x = data_out[CSTICK_X_LSB +: 8];
  assign cstick_y = data_out[CSTICK_Y_LSB +: 8];
  assign trig_l   = data_out[TRIG_L_LSB   +: 8];
  assign trig_r   = data_out[TRIG_R_LSB   +: 8];

endmodule

// File: tb/tb_gc_response_rx.sv
// Bench for gc_response_rx. The receiver runs at quarter-scale bit timing
// (100-cycle bits, 25/75-cycle low pulses, sample point 50) so that all
// scenarios fit a short run; every ratio matches the full-speed bus.
module tb_gc_response_rx;

  localparam int SD  = 50;     // sample delay
  localparam int BT  = 200;    // inter-bit timeout
  localparam int ST  = 12500;  // start timeout
  localparam int NB  = 64;
  localparam int BIT = 100;    // nominal bit period
  localparam int T1  = 25;     // low time of a 1
  localparam int T3  = 75;     // low time of a 0
  localparam int JIT = 10;     // period jitter step

  localparam logic [63:0] F1 = 64'h0080_8080_1A1A_0000;
  localparam logic [63:0] F2 = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] F3 = 64'hA5C3_0F0F_5A5A_1234;
  localparam logic [63:0] F4 = 64'h1234_5678_9ABC_DEF0;

  logic        PCLK    = 1'b0;
  logic        PRESETn = 1'b0;
  logic        read    = 1'b0;
  logic        line_in = 1'b1;
  logic [63:0] data_out;
  logic [15:0] buttons;
  logic [7:0]  joy_x, joy_y, cstick_x, cstick_y, trig_l, trig_r;
  logic        data_valid, timeout_err, busy;

  gc_response_rx #(
    .SAMPLE_DLY   (SD),
    .BIT_TIMEOUT  (BT),
    .START_TIMEOUT(ST),
    .NBITS        (NB)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .read       (read),
    .line_in    (line_in),
    .data_out   (data_out),
    .buttons    (buttons),
    .joy_x      (joy_x),
    .joy_y      (joy_y),
    .cstick_x   (cstick_x),
    .cstick_y   (cstick_y),
    .trig_l     (trig_l),
    .trig_r     (trig_r),
    .data_valid (data_valid),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    n_checks++;
    if (v >= lo && v <= hi) n_pass++;
    else $display("FAIL %s: got %0d required %0d..%0d", name, v, lo, hi);
  endtask

  // Model: the last frame that should be on data_out, and what each field
  // must read from it.
  logic [63:0] exp_data    = '0;
  logic        data_window = 1'b0;  // data_out may be changing
  logic        pulse_window = 1'b0; // a pulse is legitimately expected

  function automatic logic [127:0] model_view(input logic [63:0] f);
    return {f,
            16'((f >> 48) & 64'hFFFF),
            8'((f >> 40) & 64'hFF), 8'((f >> 32) & 64'hFF),
            8'((f >> 24) & 64'hFF), 8'((f >> 16) & 64'hFF),
            8'((f >> 8) & 64'hFF),  8'(f & 64'hFF)};
  endfunction

  // Pulse monitor.
  int dv_cnt = 0, te_cnt = 0, dv_at = -1, te_at = -1;
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (data_valid) begin
        dv_cnt <= dv_cnt + 1;
        dv_at  <= cyc;
      end
      if (timeout_err) begin
        te_cnt <= te_cnt + 1;
        te_at  <= cyc;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (!data_window)
        check("outputs", {data_out, buttons, joy_x, joy_y, cstick_x, cstick_y, trig_l, trig_r},
              model_view(exp_data));
      if (!pulse_window)
        check("no_pulse", 128'({data_valid, timeout_err}), 128'(0));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  int last_fall = 0;

  task automatic send_bit(input logic b, input int period);
    int low;
    low = b ? T1 : T3;
    line_in   = 1'b0;
    last_fall = cyc;
    wait_cyc(low);
    line_in = 1'b1;
    wait_cyc(period - low);
  endtask

  // Sends the first n bits of f, MSB first. With open_last set, the model
  // windows open just before the final bit, where the capture happens.
  task automatic send_bits(input logic [63:0] f, input int n, input bit jitter, input bit open_last);
    logic [63:0] w;
    int period;
    w = f;
    for (int i = 0; i < n; i++) begin
      period = BIT + (jitter ? ((i % 3) - 1) * JIT : 0);
      if (open_last && i == n - 1) begin
        data_window  = 1'b1;
        pulse_window = 1'b1;
      end
      send_bit(w[63 - i], period);
    end
  endtask

  task automatic wait_pulse(input bit is_dv, input int base, input int budget,
                            input int ref_cyc, output int lat);
    lat = -1;
    for (int k = 0; k < budget; k++) begin
      if (is_dv ? (dv_cnt != base) : (te_cnt != base)) begin
        lat = (is_dv ? dv_at : te_at) - ref_cyc;
        break;
      end
      wait_cyc(1);
    end
  endtask

  task automatic settle(input logic [63:0] f);
    exp_data     = f;
    data_window  = 1'b0;
    pulse_window = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_dv, base_te, lat, t0;

    // Reset state.
    wait_cyc(3);
    check("reset_outputs", 128'({data_out, data_valid, timeout_err, busy}), 128'(0));
    PRESETn = 1'b1;
    wait_cyc(20);
    check("idle_after_reset", 128'(busy), 128'(0));

    // Neutral frame plus controller stop bit.
    base_dv = dv_cnt; base_te = te_cnt;
    read = 1'b1;
    wait_cyc(3);
    check("busy_wait_start", 128'(busy), 128'(1));
    wait_cyc(7);
    send_bits(F1, 64, 1'b0, 1'b1);
    wait_pulse(1'b1, base_dv, 200, last_fall, lat);
    check_range("neutral_dv_latency", lat, SD + 2, SD + 6);
    settle(F1);
    check("neutral_joy_x", 128'(joy_x), 128'(8'h80));
    check("neutral_cstick_y", 128'(cstick_y), 128'(8'h1A));
    check("neutral_trig_r", 128'(trig_r), 128'(8'h00));
    check("neutral_buttons", 128'(buttons), 128'(16'h0080));
    send_bit(1'b1, BIT);
    wait_cyc(20);
    check("neutral_dv_count", 128'(dv_cnt - base_dv), 128'(1));
    check("neutral_te_count", 128'(te_cnt - base_te), 128'(0));
    read = 1'b0;
    wait_cyc(5);
    check("neutral_idle", 128'(busy), 128'(0));

    // All-ones then all-zeros, with +/- bit-period jitter.
    base_dv = dv_cnt;
    read = 1'b1;
    wait_cyc(10);
    send_bits(F2, 64, 1'b1, 1'b1);
    wait_pulse(1'b1, base_dv, 200, last_fall, lat);
    check_range("jitter_dv_latency", lat, SD + 2, SD + 6);
    settle(F2);
    check("jitter_data", 128'(data_out), 128'(64'hFFFF_FFFF_0000_0000));
    read = 1'b0;
    wait_cyc(10);

    // No response: start timeout.
    base_dv = dv_cnt; base_te = te_cnt;
    pulse_window = 1'b1;
    read = 1'b1;
    t0 = cyc;
    wait_pulse(1'b0, base_te, ST + 100, t0, lat);
    check_range("start_timeout_latency", lat, ST - 3, ST + 3);
    wait_cyc(3);
    check("start_timeout_busy", 128'(busy), 128'(0));
    check("start_timeout_no_dv", 128'(dv_cnt - base_dv), 128'(0));
    pulse_window = 1'b0;
    read = 1'b0;
    wait_cyc(10);

    // Truncated frame: 20 bits then silence.
    base_dv = dv_cnt; base_te = te_cnt;
    pulse_window = 1'b1;
    read = 1'b1;
    wait_cyc(10);
    send_bits(F3, 20, 1'b0, 1'b0);
    wait_pulse(1'b0, base_te, SD + BT + 100, last_fall, lat);
    check_range("bit_timeout_latency", lat, SD + BT, SD + BT + 6);
    wait_cyc(3);
    check("bit_timeout_keeps_frame", 128'(data_out), 128'(64'hFFFF_FFFF_0000_0000));
    check("bit_timeout_no_dv", 128'(dv_cnt - base_dv), 128'(0));
    pulse_window = 1'b0;
    read = 1'b0;
    wait_cyc(10);

    // Window abort after 30 bits, then a clean capture.
    base_dv = dv_cnt; base_te = te_cnt;
    read = 1'b1;
    wait_cyc(10);
    send_bits(F3, 30, 1'b0, 1'b0);
    read = 1'b0;
    wait_cyc(2);
    check("abort_idle", 128'(busy), 128'(0));
    wait_cyc(300);
    check("abort_no_pulses", 128'({dv_cnt - base_dv, te_cnt - base_te}), 128'(0));
    read = 1'b1;
    wait_cyc(10);
    send_bits(F4, 64, 1'b0, 1'b1);
    wait_pulse(1'b1, base_dv, 200, last_fall, lat);
    check_range("recapture_dv_latency", lat, SD + 2, SD + 6);
    settle(F4);
    check("recapture_data", 128'(data_out), 128'(64'h1234_5678_9ABC_DEF0));
    read = 1'b0;
    wait_cyc(10);

    // Reset in the middle of a frame.
    read = 1'b1;
    wait_cyc(10);
    send_bits(F1, 10, 1'b0, 1'b0);
    line_in  = 1'b0;
    exp_data = '0;
    PRESETn  = 1'b0;
    #1;
    check("midop_reset_outputs", 128'({data_out, data_valid, timeout_err, busy}), 128'(0));
    read = 1'b0;
    wait_cyc(5);
    line_in = 1'b1;
    PRESETn = 1'b1;
    wait_cyc(20);
    check("midop_reset_idle", 128'(busy), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
